// File: rtl/a_bus_pkg.sv
// Shared encodings between a_master_port instances and the central bus arbiter controller.
package a_bus_pkg;

    localparam logic [1:0] CmdWait   = 2'b00;
    localparam logic [1:0] CmdStopS  = 2'b01;
    localparam logic [1:0] CmdStopP  = 2'b10;
    localparam logic [1:0] CmdClear  = 2'b11;

    localparam logic [1:0] ComEnd     = 2'b00;
    localparam logic [1:0] ComNak     = 2'b01;
    localparam logic [1:0] ComWaitAck = 2'b10;
    localparam logic [1:0] ComCom     = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StReq,
        StWaitAck,
        StCom,
        StPause,
        StYield,
        StHold,
        StEnd,
        StNak
    } port_state_t;

endpackage

// File: rtl/a_ack_timer.sv
// Slave-acknowledge timeout counter; held clear outside WAIT_ACK, saturates at ACK_TIMEOUT.
module a_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_expired
);

    localparam int unsigned CntW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_expired = (r_cnt == CntW'(ACK_TIMEOUT));

endmodule

// File: rtl/a_master_port.sv
// Per-master arbitration port: request, slave-ack, grant, preemption yield and re-acquire.
// Optional ack timeout with NAK is enabled by defining A_MASTER_PORT_TIMEOUT_EN.
module a_master_port
    import a_bus_pkg::*;
#(
    parameter int unsigned NO_SLAVES   = 3,
    parameter int unsigned S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_slave,
    output logic                  grant,
    output logic                  pause,
    output logic                  pause_burst,
    input  logic                  pause_ack,
    input  logic                  core_end,
    input  logic                  slave_ack,
    output logic                  nak_flag,
    output logic [S_ID_WIDTH-1:0] id,
    output logic [1:0]            com_state,
    output logic                  done,
    input  logic [1:0]            cmd
);

    port_state_t           r_state, w_state_d;
    logic [S_ID_WIDTH-1:0] r_id, w_id_d;
    logic                  r_burst, w_burst_d;
    logic                  r_grant, r_pause, r_done, r_nak;
    logic [1:0]            r_com, w_com_d;
    logic                  w_timeout;

`ifdef A_MASTER_PORT_TIMEOUT_EN
    a_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (r_state != StWaitAck),
        .o_expired(w_timeout)
    );
`else
    // No timer: WAIT_ACK waits forever.
    assign w_timeout = 1'b0 & (ACK_TIMEOUT != 0);
`endif

    always_comb begin
        w_state_d = r_state;
        w_id_d    = r_id;
        w_burst_d = r_burst;
        unique case (r_state)
            StIdle: begin
                if (req && (req_slave != '0)) begin
                    w_state_d = StReq;
                    w_id_d    = req_slave;
                end
            end
            StReq:     if (cmd == CmdClear) w_state_d = StWaitAck;
            StWaitAck: begin
                if (slave_ack)      w_state_d = StCom;
                else if (w_timeout) w_state_d = StNak;
            end
            StCom: begin
                // core_end wins over a simultaneous STOP
                if (core_end) begin
                    w_state_d = StEnd;
                end else if (cmd == CmdStopS) begin
                    w_state_d = StPause;
                    w_burst_d = 1'b0;
                end else if (cmd == CmdStopP) begin
                    w_state_d = StPause;
                    w_burst_d = 1'b1;
                end
            end
            StPause: begin
                if (core_end)       w_state_d = StEnd;
                else if (pause_ack) w_state_d = StYield;
            end
            StYield:   w_state_d = StHold;
            StHold:    if (cmd == CmdClear) w_state_d = StWaitAck;
            StEnd:     if (cmd != CmdClear) w_state_d = StIdle;
            StNak:     w_state_d = StEnd;
            default:   w_state_d = StIdle;
        endcase
        if (w_state_d == StEnd || w_state_d == StIdle) w_id_d = '0;
        if (w_state_d != StPause && w_state_d != StYield) w_burst_d = 1'b0;
    end

    always_comb begin
        w_com_d = ComEnd;
        unique case (w_state_d)
            StWaitAck, StHold:        w_com_d = ComWaitAck;
            StCom, StPause, StYield:  w_com_d = ComCom;
            StNak:                    w_com_d = ComNak;
            default:                  w_com_d = ComEnd;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_id    <= '0;
            r_burst <= 1'b0;
            r_grant <= 1'b0;
            r_pause <= 1'b0;
            r_done  <= 1'b0;
            r_nak   <= 1'b0;
            r_com   <= ComEnd;
        end else begin
            r_state <= w_state_d;
            r_id    <= w_id_d;
            r_burst <= w_burst_d;
            r_grant <= (w_state_d == StCom) || (w_state_d == StPause);
            r_pause <= (w_state_d == StPause) || (w_state_d == StYield);
            r_done  <= (w_state_d == StYield);
            r_nak   <= (w_state_d == StNak);
            r_com   <= w_com_d;
        end
    end

    assign grant       = r_grant;
    assign pause       = r_pause;
    assign pause_burst = r_burst;
    assign done        = r_done;
    assign nak_flag    = r_nak;
    assign id          = r_id;
    assign com_state   = r_com;

endmodule

// File: tb/tb_a_master_port.sv
// Table-driven, scoreboarded bench for a_master_port (NO_SLAVES=3, ACK_TIMEOUT=4).
module tb_a_master_port;

    logic       clk = 1'b0;
    logic       rst, req, pause_ack, core_end, slave_ack;
    logic [1:0] req_slave, cmd;
    logic       grant, pause, pause_burst, nak_flag, done;
    logic [1:0] id, com_state;

    always #5 clk = ~clk;

    a_master_port #(
        .NO_SLAVES  (3),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_slave  (req_slave),
        .grant      (grant),
        .pause      (pause),
        .pause_burst(pause_burst),
        .pause_ack  (pause_ack),
        .core_end   (core_end),
        .slave_ack  (slave_ack),
        .nak_flag   (nak_flag),
        .id         (id),
        .com_state  (com_state),
        .done       (done),
        .cmd        (cmd)
    );

    typedef struct {
        string      name;
        logic       rst, req;
        logic [1:0] slv, cmd;
        logic       sack, cend, pack;
        logic [8:0] exp;  // {com_state, id, grant, pause, pause_burst, done, nak_flag}
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] sb[$];
    string      sb_name[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic vec_t v(string name, logic r, logic rq, logic [1:0] slv, logic [1:0] c,
                               logic sa, logic ce, logic pa, logic [1:0] cs, logic [1:0] i,
                               logic g, logic p, logic pb, logic d, logic n);
        vec_t t;
        t.name = name; t.rst = r; t.req = rq; t.slv = slv; t.cmd = c;
        t.sack = sa; t.cend = ce; t.pack = pa;
        t.exp  = {cs, i, g, p, pb, d, n};
        return t;
    endfunction

    task automatic apply(input vec_t t);
        logic [8:0] want;
        logic [8:0] got;
        string      nm;
        rst = t.rst; req = t.req; req_slave = t.slv; cmd = t.cmd;
        slave_ack = t.sack; core_end = t.cend; pause_ack = t.pack;
        sb.push_back(t.exp);
        sb_name.push_back(t.name);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        nm   = sb_name.pop_front();
        got  = {com_state, id, grant, pause, pause_burst, done, nak_flag};
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got cs/id/g/p/pb/d/n=%b want %b", nm, got, want);
    endtask

    // cmd shorthands
    localparam logic [1:0] W = 2'b00, SS = 2'b01, SP = 2'b10, CL = 2'b11;

    initial begin
        // Normal transaction
        tbl.push_back(v("reset",       1,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("req_id",      0,1,2,W, 0,0,0, 2'b00,2, 0,0,0,0,0));
        tbl.push_back(v("req_hold",    0,0,0,W, 0,0,0, 2'b00,2, 0,0,0,0,0));
        tbl.push_back(v("clear_wa",    0,0,0,CL,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("wa_hold",     0,0,0,W, 0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("ack_grant",   0,0,0,W, 1,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("com_hold",    0,0,0,W, 0,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("end",         0,0,0,W, 0,1,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("stale_clear", 0,1,1,CL,0,0,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("back_idle",   0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
        // STOP_S preemption and re-acquire
        tbl.push_back(v("b_req",       0,1,2,W, 0,0,0, 2'b00,2, 0,0,0,0,0));
        tbl.push_back(v("b_clear",     0,0,0,CL,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("b_ack",       0,0,0,W, 1,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("b_stop_s",    0,0,0,SS,0,0,0, 2'b11,2, 1,1,0,0,0));
        tbl.push_back(v("b_pause1",    0,0,0,W, 0,0,0, 2'b11,2, 1,1,0,0,0));
        tbl.push_back(v("b_pause2",    0,0,0,W, 0,0,0, 2'b11,2, 1,1,0,0,0));
        tbl.push_back(v("b_done",      0,0,0,W, 0,0,1, 2'b11,2, 0,1,0,1,0));
        tbl.push_back(v("b_hold1",     0,0,0,W, 0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("b_hold2",     0,0,0,SS,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("b_reclear",   0,0,0,CL,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("b_rewait",    0,0,0,W, 0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("b_regrant",   0,0,0,W, 1,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("b_end",       0,0,0,W, 0,1,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("b_idle",      0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
        // STOP_P then core_end instead of pause_ack
        tbl.push_back(v("c_req",       0,1,3,W, 0,0,0, 2'b00,3, 0,0,0,0,0));
        tbl.push_back(v("c_clear",     0,0,0,CL,0,0,0, 2'b10,3, 0,0,0,0,0));
        tbl.push_back(v("c_ack",       0,0,0,W, 1,0,0, 2'b11,3, 1,0,0,0,0));
        tbl.push_back(v("c_stop_p",    0,0,0,SP,0,0,0, 2'b11,3, 1,1,1,0,0));
        tbl.push_back(v("c_end",       0,0,0,W, 0,1,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("c_idle",      0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
        // core_end and STOP_S together
        tbl.push_back(v("d_req",       0,1,1,W, 0,0,0, 2'b00,1, 0,0,0,0,0));
        tbl.push_back(v("d_clear",     0,0,0,CL,0,0,0, 2'b10,1, 0,0,0,0,0));
        tbl.push_back(v("d_ack",       0,0,0,W, 1,0,0, 2'b11,1, 1,0,0,0,0));
        tbl.push_back(v("d_end_wins",  0,0,0,SS,0,1,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("d_idle",      0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
        // Zero slave ignored; reset in COM and in HOLD
        tbl.push_back(v("zero_slave",  0,1,0,CL,0,0,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("f_req",       0,1,2,W, 0,0,0, 2'b00,2, 0,0,0,0,0));
        tbl.push_back(v("f_clear",     0,0,0,CL,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("f_ack",       0,0,0,W, 1,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("rst_in_com",  1,0,0,SS,0,0,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("g_req",       0,1,2,W, 0,0,0, 2'b00,2, 0,0,0,0,0));
        tbl.push_back(v("g_clear",     0,0,0,CL,0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("g_ack",       0,0,0,W, 1,0,0, 2'b11,2, 1,0,0,0,0));
        tbl.push_back(v("g_stop_p",    0,0,0,SP,0,0,0, 2'b11,2, 1,1,1,0,0));
        tbl.push_back(v("g_done",      0,0,0,W, 0,0,1, 2'b11,2, 0,1,1,1,0));
        tbl.push_back(v("g_hold",      0,0,0,W, 0,0,0, 2'b10,2, 0,0,0,0,0));
        tbl.push_back(v("rst_in_hold", 1,0,0,CL,0,0,0, 2'b00,0, 0,0,0,0,0));
        tbl.push_back(v("after_rst",   0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));

        rst = 1'b1; req = 1'b0; req_slave = '0; cmd = W;
        slave_ack = 1'b0; core_end = 1'b0; pause_ack = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Ack wait without slave_ack
        apply(v("t_req",   0,1,1,W, 0,0,0, 2'b00,1, 0,0,0,0,0));
        apply(v("t_clear", 0,0,0,CL,0,0,0, 2'b10,1, 0,0,0,0,0));
`ifdef A_MASTER_PORT_TIMEOUT_EN
        for (int i = 0; i < 4; i++) apply(v("t_wait", 0,0,0,W, 0,0,0, 2'b10,1, 0,0,0,0,0));
        apply(v("t_nak",   0,0,0,W, 0,0,0, 2'b01,1, 0,0,0,0,1));
        apply(v("t_end",   0,0,0,CL,0,0,0, 2'b00,0, 0,0,0,0,0));
        apply(v("t_idle",  0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
`else
        for (int i = 0; i < 100; i++) apply(v("t_hold100", 0,0,0,W, 0,0,0, 2'b10,1, 0,0,0,0,0));
        apply(v("t_ack",   0,0,0,W, 1,0,0, 2'b11,1, 1,0,0,0,0));
        apply(v("t_end",   0,0,0,W, 0,1,0, 2'b00,0, 0,0,0,0,0));
        apply(v("t_idle",  0,0,0,W, 0,0,0, 2'b00,0, 0,0,0,0,0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
